// File: rtl/ghost_move_scheduler_if.sv
// Request/response link between the ghost move scheduler and the shared
// wall-collision checker.
interface ghost_move_scheduler_if;
    logic       chk_req;
    logic [9:0] chk_x;
    logic [8:0] chk_y;
    logic [1:0] chk_dir;
    logic       chk_ack;
    logic       chk_free;

    modport master (
        output chk_req,
        output chk_x,
        output chk_y,
        output chk_dir,
        input  chk_ack,
        input  chk_free
    );

    modport slave (
        input  chk_req,
        input  chk_x,
        input  chk_y,
        input  chk_dir,
        output chk_ack,
        output chk_free
    );
endinterface

// File: rtl/ghost_move_scheduler.sv
// Per-tick ghost movement sequencer sharing one wall-collision checker.
// Optional statistics counters are built when GHOST_SCHED_STATS_EN is defined.
//
//  state  | meaning
//  IDLE   | waiting for a movement tick (or a pending one)
//  ISSUE  | latch the current ghost's position/direction for the checker
//  WAIT   | checker request outstanding, bounded by CHK_TIMEOUT
//  COMMIT | emit step or turn pulse for the current ghost
module ghost_move_scheduler #(
    parameter int NUM_GHOSTS  = 4,
    parameter int TICK_BITS   = 17,
    parameter int CHK_TIMEOUT = 15
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic [NUM_GHOSTS*10-1:0] i_ghost_x,
    input  logic [NUM_GHOSTS*9-1:0]  i_ghost_y,
    input  logic [NUM_GHOSTS*2-1:0]  i_ghost_dir,
    ghost_move_scheduler_if.master   chk,
    output logic [NUM_GHOSTS-1:0]    o_step,
    output logic [NUM_GHOSTS-1:0]    o_turn,
    output logic [1:0]               o_new_dir,
    output logic                     o_busy,
    output logic                     o_round_done
`ifdef GHOST_SCHED_STATS_EN
    ,
    output logic [7:0]               o_overrun_cnt,
    output logic [7:0]               o_timeout_cnt
`endif
);

    localparam int         IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam logic [7:0] TMO   = 8'(CHK_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [TICK_BITS-1:0]   r_tick_cnt;
    logic [7:0]             r_lfsr;
    logic                   r_pending;
    logic [IDX_W-1:0]       r_idx;
    logic [7:0]             r_wait_cnt;
    logic                   r_blocked;
    logic                   r_chk_req;
    logic [9:0]             r_chk_x;
    logic [8:0]             r_chk_y;
    logic [1:0]             r_chk_dir;

    logic                   w_tick;
    logic                   w_lfsr_fb;
    logic                   w_start;
    logic                   w_last;
    logic                   w_ack_take;
    logic                   w_timeout;
    logic                   w_pend_set;
    logic [1:0]             w_cand;
    logic [NUM_GHOSTS-1:0]  w_onehot;
    logic [9:0]             w_sel_x;
    logic [8:0]             w_sel_y;
    logic [1:0]             w_sel_dir;

    assign w_tick     = &r_tick_cnt;
    assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_cand     = r_lfsr[1:0];
    assign w_last     = (r_idx == IDX_W'(NUM_GHOSTS - 1));
    assign w_onehot   = NUM_GHOSTS'(1) << r_idx;
    assign w_pend_set = w_tick && i_enable && (r_state != ST_IDLE) && !r_pending;

    assign chk.chk_req = r_chk_req;
    assign chk.chk_x   = r_chk_x;
    assign chk.chk_y   = r_chk_y;
    assign chk.chk_dir = r_chk_dir;

    always_comb begin
        w_sel_x   = '0;
        w_sel_y   = '0;
        w_sel_dir = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_x   = i_ghost_x[10*i +: 10];
                w_sel_y   = i_ghost_y[9*i +: 9];
                w_sel_dir = i_ghost_dir[2*i +: 2];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_ack_take   = 1'b0;
        w_timeout    = 1'b0;
        o_step       = '0;
        o_turn       = '0;
        o_new_dir    = 2'b00;
        o_round_done = 1'b0;
        o_busy       = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if ((w_tick && i_enable) || r_pending) begin
                    w_start      = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (chk.chk_ack) begin
                    w_ack_take   = 1'b1;
                    w_next_state = ST_COMMIT;
                end else if (r_wait_cnt == 8'd0) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (r_blocked) begin
                    o_turn = w_onehot;
                    // Never reload the direction the ghost already has.
                    o_new_dir = (w_cand == r_chk_dir) ? (r_chk_dir + 2'd1) : w_cand;
                end else begin
                    o_step = w_onehot;
                end
                if (w_last) begin
                    o_round_done = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_ISSUE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick_cnt <= '0;
            r_lfsr     <= 8'hA5;
            r_pending  <= 1'b0;
            r_idx      <= '0;
            r_wait_cnt <= '0;
            r_blocked  <= 1'b0;
            r_chk_req  <= 1'b0;
            r_chk_x    <= '0;
            r_chk_y    <= '0;
            r_chk_dir  <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_BITS'(1);
            r_lfsr     <= {r_lfsr[6:0], w_lfsr_fb};
            r_chk_req  <= (w_next_state == ST_WAIT);

            if (w_start) begin
                r_pending <= 1'b0;
            end else if (w_pend_set) begin
                r_pending <= 1'b1;
            end

            if (w_start) begin
                r_idx <= '0;
            end else if ((r_state == ST_COMMIT) && !w_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            // Wait budget is a down-counter; terminal count zero means timeout.
            if (r_state == ST_ISSUE) begin
                r_chk_x    <= w_sel_x;
                r_chk_y    <= w_sel_y;
                r_chk_dir  <= w_sel_dir;
                r_wait_cnt <= TMO;
            end else if (r_state == ST_WAIT) begin
                if (w_ack_take) begin
                    r_blocked <= ~chk.chk_free;
                end else if (w_timeout) begin
                    r_blocked <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt - 8'd1;
                end
            end
        end
    end

`ifdef GHOST_SCHED_STATS_EN
    logic [7:0] r_overrun_cnt;
    logic [7:0] r_timeout_cnt;
    logic       w_overrun;

    assign w_overrun = w_tick && i_enable && (r_state != ST_IDLE) && r_pending;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overrun_cnt <= '0;
            r_timeout_cnt <= '0;
        end else begin
            if (w_overrun && (r_overrun_cnt != 8'hFF)) begin
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end
            if (w_timeout && (r_timeout_cnt != 8'hFF)) begin
                r_timeout_cnt <= r_timeout_cnt + 8'd1;
            end
        end
    end

    assign o_overrun_cnt = r_overrun_cnt;
    assign o_timeout_cnt = r_timeout_cnt;
`endif

endmodule
